circle_radius_solver: RTL and testbench

- Inverse of the circle area/perimeter calculator: recovers the radius from a measured perimeter or area.
- Perimeter mode: r = P/(2*pi), one fixed-point multiply.
- Area mode: r = sqrt(A/pi), a multiply followed by a bit-serial integer square root.
- Synthesizable unsigned fixed point with a start/ready input handshake and a valid/ready output handshake. It sits downstream of geometry-measurement logic that produces P or A values.

---
 rtl/circle_radius_solver.sv | 157 +++++++++++++++
 tb/tb_circle_radius_solver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/circle_radius_solver.sv
`default_nettype none
// ============================================================================
//  Module      : circle_radius_solver
//  Description : Recovers a circle radius from a measured perimeter or area.
//                Perimeter mode : r = P / (2*pi)   (one fixed-point multiply)
//                Area mode      : r = sqrt(A / pi) (multiply, then a
//                                 bit-serial restoring integer square root)
//                All values are unsigned UQ(WIDTH-FRAC).FRAC.
//  Ports       : clk, rst_n          clock, async active-low reset
//                start/in_ready     input request handshake (mode, in_val)
//                busy               high while MUL or SQRT is in progress
//                out_valid/out_ready result handshake, radius held until taken
//                radius             result, UQ.FRAC
//  Revision    : 1.0  initial release
// ============================================================================
module circle_radius_solver #(
  parameter int WIDTH   = 32,
  parameter int FRAC    = 8,
  parameter int INV_2PI = 10430,
  parameter int INV_PI  = 20861
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_val,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] radius
);

  // Radicand is q with FRAC extra fraction bits, so its root is already UQ.FRAC.
  localparam int c_rad_w  = WIDTH + FRAC;
  localparam int c_root_w = c_rad_w / 2;
  // Partial remainder never exceeds 2*root, so root width + 2 bits suffice.
  localparam int c_rem_w  = c_root_w + 2;
  localparam int c_cnt_w  = (c_root_w > 1) ? $clog2(c_root_w) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SQRT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_mode;
  logic [WIDTH-1:0]     r_val;
  logic [c_rad_w-1:0]   r_rad;
  logic [c_root_w-1:0]  r_root;
  logic [c_rem_w-1:0]   r_rem;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_in_ready;
  logic                 r_busy;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_radius;

  logic [15:0]          w_k;
  logic [WIDTH-1:0]     w_q;
  logic [c_rem_w+1:0]   w_rem_sh;
  logic [c_rem_w+1:0]   w_trial;
  logic                 w_ge;
  logic [c_root_w-1:0]  w_root_nx;

  // Reciprocal constant is UQ0.16, so the product >> 16 always fits WIDTH bits.
  assign w_k = r_mode ? 16'(INV_PI) : 16'(INV_2PI);
  assign w_q = WIDTH'(({16'd0, r_val} * {{WIDTH{1'b0}}, w_k}) >> 16);

  // One restoring step: bring down the next two radicand bits and try to
  // subtract 4*root+1; success sets the next root bit.
  assign w_rem_sh  = {r_rem, r_rad[c_rad_w-1 -: 2]};
  assign w_trial   = {{(c_rem_w - c_root_w){1'b0}}, r_root, 2'b01};
  assign w_ge      = (w_rem_sh >= w_trial);
  assign w_root_nx = {r_root[c_root_w-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_val       <= '0;
      r_rad       <= '0;
      r_root      <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_radius    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode     <= mode;
            r_val      <= in_val;
            r_state    <= S_MUL;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        S_MUL: begin
          if (!r_mode) begin
            r_radius    <= w_q;
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_rad   <= {w_q, {FRAC{1'b0}}};
            r_root  <= '0;
            r_rem   <= '0;
            r_cnt   <= c_cnt_w'(c_root_w - 1);
            r_state <= S_SQRT;
          end
        end

        S_SQRT: begin
          r_rad  <= {r_rad[c_rad_w-3:0], 2'b00};
          r_root <= w_root_nx;
          r_rem  <= w_ge ? c_rem_w'(w_rem_sh - w_trial) : c_rem_w'(w_rem_sh);
          if (r_cnt == '0) begin
            r_radius    <= {{(WIDTH - c_root_w){1'b0}}, w_root_nx};
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_DONE: begin
          // A start coinciding with this handshake is not seen until IDLE.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign radius    = r_radius;

endmodule
`default_nettype wire

// File: tb/tb_circle_radius_solver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_circle_radius_solver
//  Description : Self-checking bench for circle_radius_solver. Expected radii
//                come from a reference model (multiply, truncate, binary-search
//                floor square root), are queued when a request is accepted and
//                popped when the result is handed over.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_circle_radius_solver;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [31:0] in_val;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] radius;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] sb[$];

  circle_radius_solver #(
    .WIDTH   (32),
    .FRAC    (8),
    .INV_2PI (10430),
    .INV_PI  (20861)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .in_val    (in_val),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .radius    (radius)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Radicand handed to the square root: truncated product, scaled by 2^FRAC.
  function automatic longint unsigned model_rad(input logic [31:0] v);
    longint unsigned p;
    p = longint'(v) * 64'd20861;
    return (p >> 16) << 8;
  endfunction

  function automatic logic [31:0] model_radius(input logic m, input logic [31:0] v);
    longint unsigned p, rad, lo, hi, mid;
    if (!m) begin
      p = longint'(v) * 64'd10430;
      return 32'(p >> 16);
    end
    rad = model_rad(v);
    lo  = 0;
    hi  = 64'd1 << 21;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= rad) lo = mid;
      else                  hi = mid;
    end
    return 32'(lo);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the negedge just after the accept edge with start released.
  task automatic finish_op(input string tag, input logic m, input bit chk_lat);
    int lat;
    int nbusy;
    logic [31:0] exp;
    lat   = 1;
    nbusy = 0;
    while (!out_valid && lat < 100) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, out_valid, 1'b1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (chk_lat) begin
      check({tag, "_latency"}, lat, m ? 22 : 2);
      check({tag, "_busy_cycles"}, nbusy, m ? 21 : 1);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_radius"}, radius, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (chk_lat) begin
      check({tag, "_valid_drop"}, out_valid, 1'b0);
      check({tag, "_ready_back"}, in_ready, 1'b1);
    end
  endtask

  task automatic run_op(input string tag, input logic m, input logic [31:0] v, input bit chk_lat);
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      check({tag, "_in_ready_timeout"}, in_ready, 1'b1);
      return;
    end
    start  = 1'b1;
    mode   = m;
    in_val = v;
    sb.push_back(model_radius(m, v));
    @(negedge clk);
    start  = 1'b0;
    // Scramble inputs to show the operation in flight uses latched values.
    in_val = $urandom;
    mode   = ~m;
    finish_op(tag, m, chk_lat);
  endtask

  initial begin
    logic [31:0]     held;
    longint unsigned rad, r;

    rst_n = 1'b1; start = 1'b0; mode = 1'b0; in_val = '0; out_ready = 1'b0;

    // Asynchronous reset assertion between clock edges, start held high.
    #12;
    rst_n = 1'b0; start = 1'b1; mode = 1'b1; in_val = 32'd100;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_radius", radius, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_busy", busy, 1'b0);
    check("rst_hold_in_ready", in_ready, 1'b1);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {in_ready, busy, out_valid}, 3'b100);

    // Directed values.
    run_op("perim_31p416", 1'b0, 32'd8042, 1'b1);
    check("perim_value_const", radius, 32'd1279);
    run_op("area_78p54", 1'b1, 32'd20106, 1'b1);
    check("area_78p54_const", radius, 32'd1280);
    run_op("area_12p57", 1'b1, 32'd3218, 1'b1);
    check("area_12p57_const", radius, 32'd512);

    // Backpressure and ignored starts.
    @(negedge clk);
    start = 1'b1; mode = 1'b1; in_val = 32'd20106;
    sb.push_back(32'd1280);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; mode = 1'b0; in_val = 32'd8042;
    @(negedge clk);
    start = 1'b0;
    check("ign_sqrt_busy", busy, 1'b1);
    check("ign_sqrt_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    check("bp_valid", out_valid, 1'b1);
    held = radius;
    check("bp_radius", held, sb[0]);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      @(negedge clk);
      check("bp_valid_hold", out_valid, 1'b1);
      check("bp_radius_hold", radius, held);
      check("bp_in_ready_low", in_ready, 1'b0);
    end
    start = 1'b0;
    void'(sb.pop_front());
    // Release with start already high: ignored on the handshake edge.
    out_ready = 1'b1; start = 1'b1; mode = 1'b1; in_val = 32'd3218;
    @(negedge clk);
    out_ready = 1'b0;
    check("rel_idle", {in_ready, busy, out_valid}, 3'b100);
    check("rel_radius_kept", radius, 32'd1280);
    sb.push_back(model_radius(1'b1, 32'd3218));
    @(negedge clk);
    start = 1'b0;
    check("rel_accept_busy", busy, 1'b1);
    check("rel_accept_in_ready", in_ready, 1'b0);
    finish_op("rel_op", 1'b1, 1'b1);

    // Boundaries.
    run_op("zero_perim", 1'b0, 32'd0, 1'b1);
    check("zero_perim_const", radius, 32'd0);
    run_op("zero_area", 1'b1, 32'd0, 1'b1);
    check("zero_area_const", radius, 32'd0);
    run_op("max_perim", 1'b0, 32'hFFFF_FFFF, 1'b0);
    run_op("max_area", 1'b1, 32'hFFFF_FFFF, 1'b1);
    rad = model_rad(32'hFFFF_FFFF);
    r   = longint'(radius);
    check("max_area_floor_lo", (r * r <= rad), 1'b1);
    check("max_area_floor_hi", ((r + 1) * (r + 1) > rad), 1'b1);

    // Reset in the middle of the square root.
    @(negedge clk);
    start = 1'b1; mode = 1'b1; in_val = 32'd20106;
    sb.push_back(32'd1280);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_radius", radius, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 1'b1, 32'd20106, 1'b1);

    // Random sweeps.
    for (int i = 0; i < 1000; i++) run_op("rand_perim", 1'b0, $urandom, 1'b0);
    for (int i = 0; i < 1000; i++) run_op("rand_area", 1'b1, $urandom, 1'b0);

    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
